// File: rtl/memory_pkg.sv
// Shared types for the memory read-side initiator: burst FSM states and output FIFO depth.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/memory_burst_reader_fifo2.sv
// Two-entry synchronous FIFO; head word visible combinationally, push/pop in the same cycle both honoured.
// Pushes while full and pops while empty are ignored, so the caller gates them on full/empty.
module fifo2
    import memory_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    output logic [N-1:0] pop_data,
    output logic         empty,
    output logic         full
);

    logic [N-1:0] r_mem [FIFO_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_cnt;
    logic         w_do_push;
    logic         w_do_pop;

    assign empty     = (r_cnt == 2'd0);
    assign full      = (r_cnt == 2'(FIFO_DEPTH));
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

endmodule

// File: rtl/memory_burst_reader.sv
// Walks a contiguous address range of the single-port memory and streams the words out on valid/ready.
// First word valid two edges after start; a full output FIFO freezes the read address until the sink drains.
module memory_burst_reader
    import memory_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] base_addr,
    input  logic [N:0]   len,
    output logic         busy,
    output logic         done,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_write,
    input  logic [N-1:0] mem_read,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    state_t       r_state;
    logic [N-1:0] r_addr;
    logic [N:0]   r_remaining;
    logic         r_busy;
    logic         r_done;
    logic         w_empty;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    assign mem_we    = 1'b0;
    assign mem_write = '0;
    assign mem_addr  = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = !w_empty;
    assign w_push    = (r_state == READ) && !w_full;
    assign w_pop     = !w_empty && out_ready;

    fifo2 #(.N(N)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (mem_read),
        .pop       (w_pop),
        .pop_data  (out_data),
        .empty     (w_empty),
        .full      (w_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_addr      <= base_addr;
                            r_remaining <= len;
                            r_state     <= READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                READ: begin
                    // Address advances only on the edge that actually captures the word.
                    if (w_push) begin
                        r_addr      <= r_addr + N'(1);
                        r_remaining <= r_remaining - (N+1)'(1);
                        if (r_remaining == (N+1)'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_burst_reader.sv
// Directed and randomized bursts checked against an address-range scoreboard of the memory contents.
module tb_memory_burst_reader;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] base_addr = '0;
    logic [N:0]   len = '0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         done;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_write;
    logic [N-1:0] mem_read;
    logic [N-1:0] out_data;
    logic         out_valid;

    logic [N-1:0] mem [2**N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_read = mem[mem_addr];

    memory_burst_reader #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode: 0 = sink always ready, 1 = random ready, 2 = 3-cycle stall after the 2nd transfer.
    // inj_cyc >= 0 drives a stray start mid-burst; rst_after > 0 resets after that many words.
    task automatic run_burst(input logic [N-1:0] b, input int n, input int mode,
                             input int inj_cyc, input int rst_after);
        logic [N-1:0] expq [$];
        int  cyc, n_x, first_x, last_x, stall, budget;
        bit  got_done, valid_seen;
        for (int k = 0; k < n; k++) begin
            logic [N-1:0] a;
            a = b + N'(k);
            expq.push_back(mem[a]);
        end
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        len       = (N+1)'(n);
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = N'($urandom);
        len       = (N+1)'($urandom);
        budget = 6 * n + 20;
        cyc = 0; n_x = 0; first_x = -1; last_x = -1; stall = 0;
        got_done = 1'b0; valid_seen = 1'b0;
        while (!got_done && cyc < budget) begin
            if (cyc == 0) begin
                chk("busy_after_start", busy, 1);
                if (n > 0) chk("addr_after_start", mem_addr, b);
            end
            if (cyc == inj_cyc) begin
                start = 1'b1; base_addr = N'(100); len = (N+1)'(5);
            end else if (cyc == inj_cyc + 1) begin
                start = 1'b0;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (n_x == 2 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                        if (stall >= 2) chk("addr_hold_full", mem_addr, b + N'(n_x + 2));
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid && !valid_seen) begin
                valid_seen = 1'b1;
                chk("first_valid_latency", cyc, 1);
            end
            if (n == 0) chk("len0_no_valid", out_valid, 0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("extra_word_index", n_x, n);
                else chk("out_data", out_data, expq.pop_front());
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                n_x++;
                if (rst_after > 0 && n_x == rst_after) begin
                    @(posedge clk);
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_valid", out_valid, 0);
                    chk("rst_done", done, 0);
                    chk("rst_addr", mem_addr, 0);
                    @(negedge clk);
                    rst = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        chk("post_rst_no_done", done, 0);
                        chk("post_rst_idle", busy, 0);
                    end
                    return;
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("busy_with_done", busy, 1);
                if (n == 0) chk("len0_done_latency", cyc, 0);
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", got_done, 1);
        chk("words_delivered", n_x, n);
        if (mode == 0 && n > 0) chk("back_to_back", last_x - first_x, n - 1);
        chk("mem_we_zero", mem_we, 0);
        chk("mem_write_zero", mem_write, 0);
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("busy_low_after", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2**N; i++) mem[i] = N'(i);
        rst = 1'b0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;

        run_burst(N'(0),   4, 0, -1, 0);
        run_burst(N'(254), 4, 0, -1, 0);
        run_burst(N'(10),  6, 2, -1, 0);
        run_burst(N'(0),   0, 0, -1, 0);
        run_burst(N'(0),   8, 0,  3, 0);
        run_burst(N'(0),  10, 0, -1, 3);
        run_burst(N'(0), 256, 0, -1, 0);

        for (int i = 0; i < 2**N; i++) mem[i] = N'($urandom);
        for (int t = 0; t < 8; t++) begin
            run_burst(N'($urandom), int'($urandom_range(1, 40)), 1, -1, 0);
        end
        run_burst(N'($urandom), 256, 1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
